// File: rtl/pong_vga_scanout.sv
// Pong pixel sink: 320x240x3 framebuffer fed by the plot stream, scanned out
// pixel-doubled as VGA. Optional macro PONG_CENTER_NET_EN overlays a dashed centre net.
module pong_vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iPlot,
    input  logic [8:0] iX,
    input  logic [7:0] iY,
    input  logic [2:0] iColour,
    output logic [7:0] oRed,
    output logic [7:0] oGreen,
    output logic [7:0] oBlue,
    output logic       oHS,
    output logic       oVS,
    output logic       oBlank_n,
    output logic       oFrameStart
);
    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int FB_DEPTH = FB_W * FB_H;

    // Porch and sync widths are fixed; only the visible area is a parameter.
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + 160 - 1);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + 16);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + 112);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + 45 - 1);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + 10);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + 12);

    // ---------------- write port ----------------
    logic        wr_en;
    logic [16:0] wr_addr;

    always_comb begin
        wr_en   = iPlot && !iReset && (iX < 9'(FB_W)) && (iY < 8'(FB_H));
        wr_addr = ({9'b0, iY} << 8) + ({9'b0, iY} << 6) + {8'b0, iX};
    end

    // ---------------- scan counters ----------------
    logic       pen_q, pen_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       frame_start_q, frame_start_d;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            pen_q         <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            pen_q         <= pen_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        pen_d         = ~pen_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        frame_start_d = 1'b0;
        if (pen_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
                // Fires together with the step into the first blanking line.
                frame_start_d = (vcnt_q == V_ACT - 10'd1);
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end
    end

    // ---------------- stage 1: flags and read issue ----------------
    logic        act_s1, hs_s1, vs_s1;
    logic [8:0]  rd_x, rd_y;
    logic [16:0] rd_addr;

    always_comb begin
        act_s1  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hs_s1   = !((hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END));
        vs_s1   = !((vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END));
        rd_x    = hcnt_q[9:1];
        rd_y    = vcnt_q[9:1];
        rd_addr = ({8'b0, rd_y} << 8) + ({8'b0, rd_y} << 6) + {8'b0, rd_x};
    end

    // Not reset: contents survive iReset. Same-address read/write returns old data.
    logic [2:0] fb_mem [FB_DEPTH];
    logic [2:0] rd_data;

    always_ff @(posedge iClock) begin
        if (wr_en)
            fb_mem[wr_addr] <= iColour;
        if (act_s1)
            rd_data <= fb_mem[rd_addr];
    end

    logic act_q, hs_q, vs_q;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            act_q <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            act_q <= act_s1;
            hs_q  <= hs_s1;
            vs_q  <= vs_s1;
        end
    end

`ifdef PONG_CENTER_NET_EN
    localparam logic [9:0] NET_LO = 10'(H_ACTIVE / 2 - 2);
    localparam logic [9:0] NET_HI = 10'(H_ACTIVE / 2 + 1);
    logic net_q;
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset)
            net_q <= 1'b0;
        else
            net_q <= (hcnt_q >= NET_LO) && (hcnt_q <= NET_HI) && !vcnt_q[4];
    end
`endif

    // ---------------- stage 2: output registers ----------------
    logic [2:0] colour_d;
    logic [7:0] red_q, green_q, blue_q;
    logic       ohs_q, ovs_q, blank_n_q;

    always_comb begin
        colour_d = 3'b000;
        if (act_q)
            colour_d = rd_data;
`ifdef PONG_CENTER_NET_EN
        if (act_q && net_q)
            colour_d = 3'b111;
`endif
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            ohs_q     <= 1'b1;
            ovs_q     <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            red_q     <= {8{colour_d[2]}};
            green_q   <= {8{colour_d[1]}};
            blue_q    <= {8{colour_d[0]}};
            ohs_q     <= hs_q;
            ovs_q     <= vs_q;
            blank_n_q <= act_q;
        end
    end

    assign oRed        = red_q;
    assign oGreen      = green_q;
    assign oBlue       = blue_q;
    assign oHS         = ohs_q;
    assign oVS         = ovs_q;
    assign oBlank_n    = blank_n_q;
    assign oFrameStart = frame_start_q;

endmodule

// File: doc/pong_vga_scanout.md
# pong_vga_scanout

Pixel sink and display scanout for the Pong video path. It accepts the per-pixel plot stream from the rectangle drawer (plot strobe, X, Y, 3-bit colour), and stores each pixel in a 320x240x3 framebuffer. It continuously reads that framebuffer out as 640x480@60 VGA timing, with every stored pixel doubled horizontally and vertically. It replaces the vendor VGA adapter as the consumer at the far end of the drawing interface.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line (scan units)
- V_ACTIVE, 480, visible lines per frame

Ports:
- iClock  in  1  system clock, 50 MHz; pixel rate is iClock/2
- iReset  in  1  asynchronous, active-high reset
- iPlot  in  1  write strobe; one pixel is written per cycle while high
- iX  in  9  write column, valid range 0..319
- iY  in  8  write row, valid range 0..239
- iColour  in  3  {R,G,B} pixel value
- oRed, oGreen, oBlue  out  8 each  DAC drive; each is the corresponding colour bit replicated 8 times
- oHS  out  1  horizontal sync, active low
- oVS  out  1  vertical sync, active low
- oBlank_n  out  1  low outside the active area
- oFrameStart  out  1  one-iClock pulse at the start of the vertical blank, used as the game's iStart

## Operation
- **Write port:**
  - On every posedge where iPlot=1, iX<320 and iY<240, write iColour to address iY*320+iX.
  - The address is 17 bits, computed as (iY<<8)+(iY<<6)+iX.
  - Out-of-range writes are silently dropped; coordinates never wrap.
  - There is no backpressure: the sink accepts every strobe.
- **Framebuffer:**
  - Simple dual-port memory with one write port and one read port, 76800x3.
  - Registered read, with 1-cycle read latency.
  - A read and a write to the same address in the same cycle returns the old data.
  - Reset does not clear the memory contents.
- **Pixel enable:**
  - The pen register toggles every iClock.
  - Counters advance only on cycles where pen=1.
- **Scan counters:**
  - hcnt runs 0..799 and wraps to 0; on that wrap, vcnt increments.
  - vcnt runs 0..524 and wraps to 0.
- **Sync generation:**
  - Active area: hcnt<640 and vcnt<480.
  - oHS is low for hcnt 656..751.
  - oVS is low for vcnt 490..491.
  - Everywhere else both syncs are high.
- **Read address:**
  - Computed as (vcnt>>1)*320 + (hcnt>>1).
  - Issued only in the active area; outside it, the output colour is forced to 0.
- **oFrameStart:** asserted for exactly one iClock, on the pen cycle where vcnt becomes 480 and hcnt becomes 0.
- **Reset:**
  - Counters and pen are cleared to 0.
  - Outputs: oHS=1, oVS=1, oBlank_n=0, oRed/oGreen/oBlue=0, oFrameStart=0.
  - Reset asserted mid-frame restarts the frame at (0,0) on the first pen cycle after release.
  - Writes are ignored while iReset=1.

## Timing
- Write latency:
  - A pixel written in cycle N is visible to a read issued in cycle N+1 or later.
  - A read issued in the same cycle N sees the old value.
- Scan pipeline has 2 stages:
  - Stage 1: counters produce the address plus active/sync flags, and the memory read is issued.
  - Stage 2: memory data plus the delayed flags are registered into all outputs.
- oRed/oGreen/oBlue, oHS, oVS and oBlank_n are mutually aligned, and all lag the counter state by 2 iClock.
- Each scan pixel is held for 2 iClock (25 MHz).
- Line period: 1600 iClock. Frame period: 840000 iClock.
- Writes and scanout are fully concurrent and never stall each other.

## Configuration
- PONG_CENTER_NET_EN:
  - **Defined:** the output colour is forced to 3'b111 where hcnt is 318..321 (inside the active area) and bit 4 of vcnt is 0, giving a dashed 4-pixel-wide net over the framebuffer content. Syncs and blanking are unchanged.
  - **Undefined:** the output is pure framebuffer data.

## Test plan
- **Reset values:** assert iReset mid-frame -> outputs immediately read oHS=1, oVS=1, oBlank_n=0, RGB=0. After release, the first oHS falling edge occurs 2+2*656 iClock after the first pen cycle.
- **Sync timing:** run 2 frames -> oHS low for 192 iClock every 1600; oVS low for 3200 iClock every 840000; oFrameStart is one pulse per frame, 480*1600 iClock after frame start.
- **Pixel write/read:** plot (iX=5, iY=3, colour 3'b100) -> scan lines 6-7, columns 10-11 output oRed=8'hFF, oGreen=0, oBlue=0. Neighbouring pixels keep their prior values.
- **Bounds:** plot iX=320 and iY=240 with colour 3'b111 -> no framebuffer location changes; (0,0) and (319,239) accept writes normally.
- **Write/read collision:** write a new colour to the address being read in the same cycle -> the old colour is displayed for that pixel; the new colour appears on the next frame.
- **Net option:** with PONG_CENTER_NET_EN defined and a black framebuffer -> white at hcnt 318..321 for vcnt 0..15, black for vcnt 16..31. Without the macro -> all black.
